// File: rtl/multi_source_light_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_source_light_mux: NCH-way registered light-pattern mux with        |
// | blanked switch-over; optional auto-scan built when AUTO_SCAN_EN is set.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multi_source_light_mux #(
  parameter  int NCH   = 4,
  parameter  int WIDTH = 3,
  parameter  int BLANK = 2,
  parameter  int DWELL = 8,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SELW-1:0]      sel,
  input  logic                 auto,
  input  logic [NCH*WIDTH-1:0] src_bus,
  output logic [WIDTH-1:0]     result,
  output logic [SELW-1:0]      active,
  output logic                 blanking
);

  typedef enum logic [0:0] {
    S_SHOW  = 1'b0,
    S_BLANK = 1'b1
  } state_t;

  localparam logic [SELW:0]   c_NCH        = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] c_LAST       = SELW'(NCH-1);
  localparam logic [7:0]      c_BLANK_LOAD = 8'(BLANK-1);

  state_t           r_state;
  logic [7:0]       r_blank_cnt;
  logic [WIDTH-1:0] w_src [NCH];
  logic             w_sel_ok;
  logic [SELW-1:0]  w_manual_tgt;
  logic [SELW-1:0]  w_target;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
    assign w_src[gi] = src_bus[gi*WIDTH +: WIDTH];
  end

  // Out-of-range requests leave the committed channel untouched.
  assign w_sel_ok     = ({1'b0, sel} < c_NCH);
  assign w_manual_tgt = w_sel_ok ? sel : active;

`ifdef AUTO_SCAN_EN
  logic [15:0]     r_dwell;
  logic            w_dwell_done;
  logic [SELW-1:0] w_next_ch;

  assign w_dwell_done = (r_dwell == 16'(DWELL-1));
  assign w_next_ch    = (active == c_LAST) ? '0 : active + SELW'(1);
  assign w_target     = auto ? (w_dwell_done ? w_next_ch : active) : w_manual_tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell <= '0;
    end else if ((r_state != S_SHOW) || !auto || (w_target != active)) begin
      r_dwell <= '0;
    end else begin
      r_dwell <= r_dwell + 16'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{auto, 1'(DWELL)};
  assign w_target = w_manual_tgt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_SHOW;
      active      <= '0;
      result      <= '0;
      blanking    <= 1'b0;
      r_blank_cnt <= '0;
    end else begin
      case (r_state)
        S_SHOW: begin
          if (w_target != active) begin
            active <= w_target;
            if (BLANK > 0) begin
              r_state     <= S_BLANK;
              result      <= '0;
              blanking    <= 1'b1;
              r_blank_cnt <= c_BLANK_LOAD;
            end else begin
              result <= w_src[w_target];
            end
          end else begin
            result <= w_src[active];
          end
        end
        S_BLANK: begin
          if (r_blank_cnt == 8'd0) begin
            r_state  <= S_SHOW;
            blanking <= 1'b0;
            result   <= w_src[active];
          end else begin
            r_blank_cnt <= r_blank_cnt - 8'd1;
          end
        end
        default: r_state <= S_SHOW;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_source_light_mux.sv
`default_nettype none
// Bench for multi_source_light_mux: three configurations (default, NCH=3,
// BLANK=0) share stimulus and are checked against a timeline-based model.
module tb_multi_source_light_mux;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        auto;
  logic [11:0] src;
  logic [2:0]  res [NI];
  logic [1:0]  act [NI];
  logic        blk [NI];

  int m_nch   [NI] = '{4, 3, 4};
  int m_blank [NI] = '{2, 2, 0};
  int m_dwell [NI] = '{8, 8, 5};
  int m_act   [NI];
  int m_res   [NI];
  int m_blk   [NI];
  int m_sw    [NI];
  int m_dw    [NI];
  int edge_n  = 0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_source_light_mux #(.NCH(4), .WIDTH(3), .BLANK(2), .DWELL(8)) u_d4 (
    .clk(clk), .rst(rst), .sel(sel), .auto(auto), .src_bus(src),
    .result(res[0]), .active(act[0]), .blanking(blk[0])
  );

  multi_source_light_mux #(.NCH(3), .WIDTH(3), .BLANK(2), .DWELL(8)) u_d3 (
    .clk(clk), .rst(rst), .sel(sel), .auto(auto), .src_bus(src[8:0]),
    .result(res[1]), .active(act[1]), .blanking(blk[1])
  );

  multi_source_light_mux #(.NCH(4), .WIDTH(3), .BLANK(0), .DWELL(5)) u_d0 (
    .clk(clk), .rst(rst), .sel(sel), .auto(auto), .src_bus(src),
    .result(res[2]), .active(act[2]), .blanking(blk[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int chan(int c);
    return int'((src >> (c * 3)) & 12'h7);
  endfunction

  function automatic bit auto_eff();
`ifdef AUTO_SCAN_EN
    return auto;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_act[i] = 0; m_res[i] = 0; m_blk[i] = 0; m_dw[i] = 0; m_sw[i] = -1000;
    end
  endtask

  // A switch at edge s blanks edges s..s+BLANK-1; edge s+BLANK shows the new channel.
  task automatic model_edge();
    int tgt;
    edge_n++;
    for (int i = 0; i < NI; i++) begin
      if (edge_n < m_sw[i] + m_blank[i]) begin
        m_res[i] = 0; m_blk[i] = 1;
      end else if (m_blank[i] > 0 && edge_n == m_sw[i] + m_blank[i]) begin
        m_res[i] = chan(m_act[i]); m_blk[i] = 0; m_dw[i] = 0;
      end else begin
        tgt = m_act[i];
        if (auto_eff()) begin
          if (m_dw[i] == m_dwell[i] - 1) tgt = (m_act[i] + 1) % m_nch[i];
        end else if (int'(sel) < m_nch[i]) begin
          tgt = int'(sel);
        end
        if (tgt != m_act[i]) begin
          m_act[i] = tgt; m_sw[i] = edge_n; m_dw[i] = 0;
          if (m_blank[i] > 0) begin m_res[i] = 0; m_blk[i] = 1; end
          else m_res[i] = chan(tgt);
        end else begin
          m_res[i] = chan(m_act[i]);
          m_dw[i]  = auto_eff() ? m_dw[i] + 1 : 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("res%0d@%0d", i, edge_n), res[i], m_res[i]);
      check($sformatf("act%0d@%0d", i, edge_n), act[i], m_act[i]);
      check($sformatf("blk%0d@%0d", i, edge_n), blk[i], m_blk[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_wrap;
    int prev_act;
    bit done;

    rst = 1'b1; sel = 2'd0; auto = 1'b0; src = 12'hFAC;
    model_reset();
    step(); step();
    rst = 1'b0;
    step();
    check("post_rst_ch0", res[0], 3'b100);

    // Manual switch 0 -> 2
    step();
    sel = 2'd2;
    step();
    check("sw_blank_k", blk[0], 1'b1);
    step();
    step();
    check("sw_ch2", res[0], 3'b110);
    check("sw_noblank_b0", blk[2], 1'b0);

    // Invalid select on the three-channel instance
    sel = 2'd0;
    repeat (4) step();
    sel = 2'd3;
    repeat (4) step();
    check("inv_act", act[1], 2'd0);
    check("inv_blk", blk[1], 1'b0);

    // Switch request arriving during blanking
    sel = 2'd0;
    repeat (4) step();
    sel = 2'd1;
    step();
    sel = 2'd3;
    repeat (8) step();
    check("dbl_sw_ch3", res[0], 3'b111);

    // Asynchronous reset mid-blank
    sel = (m_act[0] == 1) ? 2'd2 : 2'd1;
    step();
    check("mid_blank", blk[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    step();
    rst = 1'b0;
    step();

    // BLANK=0 direct switch 1 -> 3
    sel = 2'd1;
    repeat (3) step();
    src = 12'(($urandom & 12'hFFF) | 12'h800);
    sel = 2'd3;
    step();
    check("b0_direct", res[2], chan(3));

    // Auto scan: measure rotation period on the default instance
    auto = 1'b1;
    first_wrap = -1;
    done = 1'b0;
    prev_act = int'(act[0]);
    for (int c = 0; c < 200 && !done; c++) begin
      src = 12'($urandom);
      step();
      if (prev_act != 0 && act[0] == 2'd0) begin
        if (first_wrap < 0) first_wrap = edge_n;
        else begin
          check("scan_period", edge_n - first_wrap, 40);
          done = 1'b1;
        end
      end
      prev_act = int'(act[0]);
    end
`ifdef AUTO_SCAN_EN
    if (!done) check("scan_period_timeout", 0, 1);
`endif
    auto = 1'b0;

    // Randomised mixed traffic
    for (int c = 0; c < 400; c++) begin
      src = 12'($urandom);
      if ($urandom_range(0, 3) == 0) sel = 2'($urandom);
      if ($urandom_range(0, 40) == 0) auto = ~auto;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
